pll_supervisor: RTL and testbench
=================================

// Module: pll_supervisor
// PURPOSE
// Sequences and supervises an ECP5 EHXPLLL (or any PLL with active-high RST and LOCK) from the
// always-running reference clock. Pulses PLL reset, waits for lock with timeout and bounded
// retries, qualifies lock stability, then releases N_DOMAINS reset requests in staggered order.
// On lock loss it re-asserts all domain resets and restarts the PLL. Outputs feed per-domain
// reset synchronisers in the generated-clock domains.
// PARAMETERS
// N_DOMAINS           3      number of staggered reset outputs (>=1)
// PLL_RST_CYCLES      16     cycles pll_rst is held high per reset attempt (>=1)
// LOCK_TIMEOUT_CYCLES 65536  max cycles in WAIT_LOCK before one retry is counted (>=1)
// LOCK_STABLE_CYCLES  1024   consecutive synchronised-lock-high cycles required (>=1)
// STAGGER_CYCLES      16     gap between consecutive domain releases (>=1)
// MAX_RETRIES         3      failed lock attempts before FAULT (1..15)
// PORTS
// clk             in   1          reference clock (PLL CLKI), free-running
// rst_n           in   1          synchronous active-low reset
// pll_locked      in   1          PLL LOCK, asynchronous; 2-flop synchronised internally
// sw_restart      in   1          one-cycle pulse: restart whole sequence, clear fault
// pll_rst         out  1          to PLL RST, active high
// domain_rst_n    out  N_DOMAINS  per-domain reset request, active low
// running         out  1          all domains released, lock good
// fault           out  1          sticky: MAX_RETRIES attempts failed
// lock_loss_count out  8          lock losses seen in RELEASE/RUN, saturates at 255
// BEHAVIOUR
// - All outputs registered. While rst_n=0: pll_rst=1, domain_rst_n=0, running=0, fault=0,
//   lock_loss_count=0, retries=0, state=PLL_RST, counter=0, sync flops=0.
// - lock_s = pll_locked after 2 flops; every state decision uses lock_s (2-cycle latency).
// - States: PLL_RST, WAIT_LOCK, STABLE, RELEASE, RUN, FAULT.
// - PLL_RST: pll_rst=1 for exactly PLL_RST_CYCLES cycles, then WAIT_LOCK, counter cleared.
// - WAIT_LOCK: pll_rst=0. lock_s=1 -> STABLE. Counter reaching LOCK_TIMEOUT_CYCLES -> retries+1;
//   if retries+1==MAX_RETRIES -> FAULT, else PLL_RST.
// - STABLE: lock_s=0 -> WAIT_LOCK with timeout counter restarted (no retry counted).
//   LOCK_STABLE_CYCLES consecutive lock_s=1 -> RELEASE; domain_rst_n[0] rises on first RELEASE cycle.
// - RELEASE: domain_rst_n[i] rises exactly i*STAGGER_CYCLES cycles after domain_rst_n[0]; once
//   domain N_DOMAINS-1 released -> RUN, running=1 same cycle, retries cleared.
// - RUN / RELEASE lock loss (lock_s=0): next cycle domain_rst_n=all 0, running=0, pll_rst=1,
//   state=PLL_RST, lock_loss_count+1 (saturating). Released domains never release out of order.
// - FAULT: pll_rst=1, domain_rst_n=0, fault=1, held until rst_n=0 or sw_restart.
// - sw_restart (any state, priority over all transitions except rst_n): next cycle state=PLL_RST,
//   counter=0, retries=0, fault=0, domain_rst_n=0, running=0; lock_loss_count kept.
// - N_DOMAINS=1: RELEASE lasts one cycle. Counters sized by $clog2 of their limit; no wrap.
// TESTING (N_DOMAINS=3, PLL_RST=4, TIMEOUT=32, STABLE=8, STAGGER=4, MAX_RETRIES=2)
// - Reset release, lock rises 10 cycles later and stays -> pll_rst high 4 cycles; domain 0 rises
//   2+8 cycles after lock, domains 1/2 at +4/+8; running with domain 2; count=0.
// - Lock never rises -> two 4-cycle pll_rst pulses 32 WAIT cycles apart, then fault=1,
//   pll_rst=1, domains held; sw_restart pulse -> fault=0, new 4-cycle pll_rst sequence.
// - Lock glitches low for 1 cycle at STABLE cycle 5 -> back to WAIT_LOCK, no retry, release
//   only after 8 fresh consecutive good cycles.
// - Lock drops in RUN -> 3 cycles later all domain_rst_n=0, running=0, pll_rst=1,
//   lock_loss_count=1; relock -> full re-release in order 0,1,2.
// - Lock drops between domain 0 and 1 release -> all domains reset together, domain 1/2 never
//   rise; 256 losses -> lock_loss_count stays 255.
// - rst_n low mid-RUN -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/pll_supervisor.sv
// PLL reset sequencer and lock supervisor. It pulses the PLL reset and waits for lock with a timeout and bounded retries.
// After lock is qualified as stable, it releases the domain resets in staggered order.
module pll_supervisor #(
   parameter int N_DOMAINS           = 3,
   parameter int PLL_RST_CYCLES      = 16,
   parameter int LOCK_TIMEOUT_CYCLES = 65536,
   parameter int LOCK_STABLE_CYCLES  = 1024,
   parameter int STAGGER_CYCLES      = 16,
   parameter int MAX_RETRIES         = 3
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 pll_locked,
   input  logic                 sw_restart,
   output logic                 pll_rst,
   output logic [N_DOMAINS-1:0] domain_rst_n,
   output logic                 running,
   output logic                 fault,
   output logic [7:0]           lock_loss_count
);

   localparam int CMAX0 = (PLL_RST_CYCLES > LOCK_TIMEOUT_CYCLES) ? PLL_RST_CYCLES : LOCK_TIMEOUT_CYCLES;
   localparam int CMAX1 = (LOCK_STABLE_CYCLES > STAGGER_CYCLES) ? LOCK_STABLE_CYCLES : STAGGER_CYCLES;
   localparam int CMAX  = (CMAX0 > CMAX1) ? CMAX0 : CMAX1;
   localparam int CW    = $clog2(CMAX + 1);
   localparam int IW    = (N_DOMAINS > 1) ? $clog2(N_DOMAINS) : 1;

   localparam logic [CW-1:0] RST_LAST  = CW'(PLL_RST_CYCLES - 1);
   localparam logic [CW-1:0] TMO_LAST  = CW'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [CW-1:0] STB_LAST  = CW'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CW-1:0] STG_LAST  = CW'(STAGGER_CYCLES - 1);
   localparam logic [IW-1:0] LAST_IDX  = IW'(N_DOMAINS - 1);
   localparam logic [3:0]    RETRY_MAX = 4'(MAX_RETRIES);

   localparam logic [2:0] S_PLL_RST = 3'd0;
   localparam logic [2:0] S_WAIT    = 3'd1;
   localparam logic [2:0] S_STABLE  = 3'd2;
   localparam logic [2:0] S_RELEASE = 3'd3;
   localparam logic [2:0] S_RUN     = 3'd4;
   localparam logic [2:0] S_FAULT   = 3'd5;

   logic [2:0]    state;
   logic [CW-1:0] cnt;
   logic [3:0]    retries;
   logic [IW-1:0] dom_idx;
   logic          sync1, lock_s;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state           <= S_PLL_RST;
         cnt             <= '0;
         retries         <= '0;
         dom_idx         <= '0;
         sync1           <= 1'b0;
         lock_s          <= 1'b0;
         pll_rst         <= 1'b1;
         domain_rst_n    <= '0;
         running         <= 1'b0;
         fault           <= 1'b0;
         lock_loss_count <= '0;
      end else begin
         sync1  <= pll_locked;
         lock_s <= sync1;
         if (sw_restart) begin
            state        <= S_PLL_RST;
            cnt          <= '0;
            retries      <= '0;
            fault        <= 1'b0;
            domain_rst_n <= '0;
            running      <= 1'b0;
            pll_rst      <= 1'b1;
         end else begin
            case (state)
               S_PLL_RST: begin
                  if (cnt == RST_LAST) begin
                     state   <= S_WAIT;
                     cnt     <= '0;
                     pll_rst <= 1'b0;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               S_WAIT: begin
                  // The cycle that first sees lock counts as the first good cycle.
                  if (lock_s) begin
                     cnt <= CW'(1);
                     if (LOCK_STABLE_CYCLES == 1) begin
                        state           <= S_RELEASE;
                        cnt             <= '0;
                        dom_idx         <= IW'(1);
                        domain_rst_n[0] <= 1'b1;
                     end else begin
                        state <= S_STABLE;
                     end
                  end else if (cnt == TMO_LAST) begin
                     cnt     <= '0;
                     retries <= retries + 1'b1;
                     pll_rst <= 1'b1;
                     if (retries + 4'd1 == RETRY_MAX) begin
                        state <= S_FAULT;
                        fault <= 1'b1;
                     end else begin
                        state <= S_PLL_RST;
                     end
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               S_STABLE: begin
                  if (!lock_s) begin
                     state <= S_WAIT;
                     cnt   <= '0;
                  end else if (cnt >= STB_LAST) begin
                     state           <= S_RELEASE;
                     cnt             <= '0;
                     dom_idx         <= IW'(1);
                     domain_rst_n[0] <= 1'b1;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               S_RELEASE, S_RUN: begin
                  // Lock loss drops every domain together, so none can be left released out of order.
                  if (!lock_s) begin
                     state        <= S_PLL_RST;
                     cnt          <= '0;
                     pll_rst      <= 1'b1;
                     domain_rst_n <= '0;
                     running      <= 1'b0;
                     if (lock_loss_count != 8'hFF) lock_loss_count <= lock_loss_count + 1'b1;
                  end else if (state == S_RELEASE) begin
                     if (N_DOMAINS == 1) begin
                        state   <= S_RUN;
                        running <= 1'b1;
                        retries <= '0;
                     end else if (cnt == STG_LAST) begin
                        cnt                   <= '0;
                        domain_rst_n[dom_idx] <= 1'b1;
                        if (dom_idx == LAST_IDX) begin
                           state   <= S_RUN;
                           running <= 1'b1;
                           retries <= '0;
                        end else begin
                           dom_idx <= dom_idx + 1'b1;
                        end
                     end else begin
                        cnt <= cnt + 1'b1;
                     end
                  end
               end
               S_FAULT: begin
                  pll_rst      <= 1'b1;
                  domain_rst_n <= '0;
                  fault        <= 1'b1;
               end
               default: begin
                  state   <= S_PLL_RST;
                  cnt     <= '0;
                  pll_rst <= 1'b1;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_pll_supervisor.sv
// Scenario bench for pll_supervisor: expected output snapshots are queued per scenario.
// Each snapshot is compared against the DUT at the cycle it is due.
module tb_pll_supervisor;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       pll_locked = 1'b0;
   logic       sw_restart = 1'b0;
   logic       pll_rst;
   logic [2:0] domain_rst_n;
   logic       running;
   logic       fault;
   logic [7:0] lock_loss_count;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int         cyc;
      logic       pr;
      logic [2:0] d;
      logic       r;
      logic       f;
      logic [7:0] n;
      string      nm;
   } exp_t;

   exp_t sb[$];

   pll_supervisor #(
      .N_DOMAINS(3), .PLL_RST_CYCLES(4), .LOCK_TIMEOUT_CYCLES(32),
      .LOCK_STABLE_CYCLES(8), .STAGGER_CYCLES(4), .MAX_RETRIES(2)
   ) dut (
      .clk(clk), .rst_n(rst_n), .pll_locked(pll_locked), .sw_restart(sw_restart),
      .pll_rst(pll_rst), .domain_rst_n(domain_rst_n), .running(running),
      .fault(fault), .lock_loss_count(lock_loss_count)
   );

   always #5 clk = ~clk;

   function automatic void push(int c, logic pr, logic [2:0] d, logic r, logic f, logic [7:0] n, string nm);
      exp_t e;
      e.cyc = c; e.pr = pr; e.d = d; e.r = r; e.f = f; e.n = n; e.nm = nm;
      sb.push_back(e);
   endfunction

   task automatic test_reset();
      exp_t e;
      sb.delete();
      rst_n = 1'b0; pll_locked = 1'b1; sw_restart = 1'b0;
      for (int i = 0; i < 3; i++) push(i, 1, 3'b000, 0, 0, 8'd0, "reset_vals");
      for (int t = 0; t < 3; t++) begin
         @(posedge clk); #1;
         while (sb.size() > 0 && sb[0].cyc == t) begin
            e = sb.pop_front(); checks++;
            if ({pll_rst, domain_rst_n, running, fault, lock_loss_count} !== {e.pr, e.d, e.r, e.f, e.n}) begin
               errors++;
               $display("FAIL %s t=%0d: got rst=%b dom=%b run=%b flt=%b cnt=%0d, expected rst=%b dom=%b run=%b flt=%b cnt=%0d",
                        e.nm, t, pll_rst, domain_rst_n, running, fault, lock_loss_count, e.pr, e.d, e.r, e.f, e.n);
            end
         end
      end
      pll_locked = 1'b0;
   endtask

   task automatic test_normal();
      exp_t e;
      sb.delete();
      rst_n = 1'b0; pll_locked = 1'b0;
      push(0,  1, 3'b000, 0, 0, 8'd0, "pllrst_first");
      push(3,  1, 3'b000, 0, 0, 8'd0, "pllrst_last");
      push(4,  0, 3'b000, 0, 0, 8'd0, "pllrst_drop");
      push(19, 0, 3'b000, 0, 0, 8'd0, "pre_d0");
      push(20, 0, 3'b001, 0, 0, 8'd0, "d0_rise");
      push(23, 0, 3'b001, 0, 0, 8'd0, "pre_d1");
      push(24, 0, 3'b011, 0, 0, 8'd0, "d1_rise");
      push(27, 0, 3'b011, 0, 0, 8'd0, "pre_d2");
      push(28, 0, 3'b111, 1, 0, 8'd0, "d2_running");
      push(40, 0, 3'b111, 1, 0, 8'd0, "run_hold");
      for (int t = 0; t <= 40; t++) begin
         @(posedge clk); #1;
         while (sb.size() > 0 && sb[0].cyc == t) begin
            e = sb.pop_front(); checks++;
            if ({pll_rst, domain_rst_n, running, fault, lock_loss_count} !== {e.pr, e.d, e.r, e.f, e.n}) begin
               errors++;
               $display("FAIL %s t=%0d: got rst=%b dom=%b run=%b flt=%b cnt=%0d, expected rst=%b dom=%b run=%b flt=%b cnt=%0d",
                        e.nm, t, pll_rst, domain_rst_n, running, fault, lock_loss_count, e.pr, e.d, e.r, e.f, e.n);
            end
         end
         if (t == 0)  rst_n = 1'b1;
         if (t == 10) pll_locked = 1'b1;
      end
      checks++;
      if (sb.size() != 0) begin errors++; $display("FAIL normal_queue: %0d expectations left, expected 0", sb.size()); end
   endtask

   task automatic test_lock_loss_run();
      exp_t e;
      sb.delete();
      push(2,  0, 3'b111, 1, 0, 8'd0, "loss_pre");
      push(3,  1, 3'b000, 0, 0, 8'd1, "loss_reset");
      push(6,  1, 3'b000, 0, 0, 8'd1, "loss_pllrst_last");
      push(7,  0, 3'b000, 0, 0, 8'd1, "loss_pllrst_drop");
      push(14, 0, 3'b000, 0, 0, 8'd1, "re_pre_d0");
      push(15, 0, 3'b001, 0, 0, 8'd1, "re_d0");
      push(18, 0, 3'b001, 0, 0, 8'd1, "re_pre_d1");
      push(19, 0, 3'b011, 0, 0, 8'd1, "re_d1");
      push(22, 0, 3'b011, 0, 0, 8'd1, "re_pre_d2");
      push(23, 0, 3'b111, 1, 0, 8'd1, "re_d2_running");
      for (int t = 0; t <= 25; t++) begin
         @(posedge clk); #1;
         while (sb.size() > 0 && sb[0].cyc == t) begin
            e = sb.pop_front(); checks++;
            if ({pll_rst, domain_rst_n, running, fault, lock_loss_count} !== {e.pr, e.d, e.r, e.f, e.n}) begin
               errors++;
               $display("FAIL %s t=%0d: got rst=%b dom=%b run=%b flt=%b cnt=%0d, expected rst=%b dom=%b run=%b flt=%b cnt=%0d",
                        e.nm, t, pll_rst, domain_rst_n, running, fault, lock_loss_count, e.pr, e.d, e.r, e.f, e.n);
            end
         end
         if (t == 0) pll_locked = 1'b0;
         if (t == 3) pll_locked = 1'b1;
      end
      checks++;
      if (sb.size() != 0) begin errors++; $display("FAIL loss_queue: %0d expectations left, expected 0", sb.size()); end
   endtask

   // Lock is dropped every 15 cycles: 3 cycles after each drop a loss is taken, and domain 0 is back 12 cycles later.
   task automatic test_release_loss_saturate();
      exp_t e;
      sb.delete();
      push(3,  1, 3'b000, 0, 0, 8'd2, "loss1");
      push(14, 0, 3'b000, 0, 0, 8'd2, "pre_rel1");
      push(15, 0, 3'b001, 0, 0, 8'd2, "rel1_d0");
      push(17, 0, 3'b001, 0, 0, 8'd2, "rel1_hold");
      push(18, 1, 3'b000, 0, 0, 8'd3, "loss_in_release");
      push(19, 1, 3'b000, 0, 0, 8'd3, "d1_never");
      push(23, 0, 3'b000, 0, 0, 8'd3, "d2_never");
      push(30, 0, 3'b001, 0, 0, 8'd3, "rel2_d0");
      for (int i = 253; i <= 262; i++)
         push(15 * i - 12, 1, 3'b000, 0, 0, (i >= 254) ? 8'd255 : 8'(1 + i), "loss_saturate");
      for (int t = 0; t <= 3920; t++) begin
         @(posedge clk); #1;
         while (sb.size() > 0 && sb[0].cyc == t) begin
            e = sb.pop_front(); checks++;
            if ({pll_rst, domain_rst_n, running, fault, lock_loss_count} !== {e.pr, e.d, e.r, e.f, e.n}) begin
               errors++;
               $display("FAIL %s t=%0d: got rst=%b dom=%b run=%b flt=%b cnt=%0d, expected rst=%b dom=%b run=%b flt=%b cnt=%0d",
                        e.nm, t, pll_rst, domain_rst_n, running, fault, lock_loss_count, e.pr, e.d, e.r, e.f, e.n);
            end
         end
         if (t % 15 == 0)      pll_locked = 1'b0;
         else if (t % 15 == 3) pll_locked = 1'b1;
      end
      checks++;
      if (sb.size() != 0) begin errors++; $display("FAIL sat_queue: %0d expectations left, expected 0", sb.size()); end
   endtask

   task automatic test_restart_and_reset();
      exp_t e;
      sb.delete();
      push(40, 0, 3'b111, 1, 0, 8'd255, "run_before_restart");
      push(41, 1, 3'b000, 0, 0, 8'd255, "sw_restart_run");
      push(52, 0, 3'b000, 0, 0, 8'd255, "restart_pre_d0");
      push(53, 0, 3'b001, 0, 0, 8'd255, "restart_d0");
      push(57, 0, 3'b011, 0, 0, 8'd255, "restart_d1");
      push(61, 0, 3'b111, 1, 0, 8'd255, "restart_running");
      push(71, 1, 3'b000, 0, 0, 8'd0,   "rst_mid_run");
      push(72, 1, 3'b000, 0, 0, 8'd0,   "rst_hold");
      for (int t = 0; t <= 72; t++) begin
         @(posedge clk); #1;
         while (sb.size() > 0 && sb[0].cyc == t) begin
            e = sb.pop_front(); checks++;
            if ({pll_rst, domain_rst_n, running, fault, lock_loss_count} !== {e.pr, e.d, e.r, e.f, e.n}) begin
               errors++;
               $display("FAIL %s t=%0d: got rst=%b dom=%b run=%b flt=%b cnt=%0d, expected rst=%b dom=%b run=%b flt=%b cnt=%0d",
                        e.nm, t, pll_rst, domain_rst_n, running, fault, lock_loss_count, e.pr, e.d, e.r, e.f, e.n);
            end
         end
         if (t == 40) sw_restart = 1'b1;
         if (t == 41) sw_restart = 1'b0;
         if (t == 70) rst_n = 1'b0;
      end
      checks++;
      if (sb.size() != 0) begin errors++; $display("FAIL restart_queue: %0d expectations left, expected 0", sb.size()); end
   endtask

   task automatic test_never_lock();
      exp_t e;
      sb.delete();
      rst_n = 1'b0; pll_locked = 1'b0;
      push(3,   1, 3'b000, 0, 0, 8'd0, "try1_pllrst_last");
      push(4,   0, 3'b000, 0, 0, 8'd0, "try1_wait");
      push(35,  0, 3'b000, 0, 0, 8'd0, "try1_wait_last");
      push(36,  1, 3'b000, 0, 0, 8'd0, "try2_pllrst");
      push(39,  1, 3'b000, 0, 0, 8'd0, "try2_pllrst_last");
      push(40,  0, 3'b000, 0, 0, 8'd0, "try2_wait");
      push(71,  0, 3'b000, 0, 0, 8'd0, "try2_wait_last");
      push(72,  1, 3'b000, 0, 1, 8'd0, "fault_set");
      push(100, 1, 3'b000, 0, 1, 8'd0, "fault_sticky");
      push(101, 1, 3'b000, 0, 0, 8'd0, "fault_cleared");
      push(104, 1, 3'b000, 0, 0, 8'd0, "restart_pllrst_last");
      push(105, 0, 3'b000, 0, 0, 8'd0, "restart_wait");
      for (int t = 0; t <= 106; t++) begin
         @(posedge clk); #1;
         while (sb.size() > 0 && sb[0].cyc == t) begin
            e = sb.pop_front(); checks++;
            if ({pll_rst, domain_rst_n, running, fault, lock_loss_count} !== {e.pr, e.d, e.r, e.f, e.n}) begin
               errors++;
               $display("FAIL %s t=%0d: got rst=%b dom=%b run=%b flt=%b cnt=%0d, expected rst=%b dom=%b run=%b flt=%b cnt=%0d",
                        e.nm, t, pll_rst, domain_rst_n, running, fault, lock_loss_count, e.pr, e.d, e.r, e.f, e.n);
            end
         end
         if (t == 0)   rst_n = 1'b1;
         if (t == 100) sw_restart = 1'b1;
         if (t == 101) sw_restart = 1'b0;
      end
      checks++;
      if (sb.size() != 0) begin errors++; $display("FAIL never_queue: %0d expectations left, expected 0", sb.size()); end
   endtask

   task automatic test_glitch();
      exp_t e;
      sb.delete();
      rst_n = 1'b0; pll_locked = 1'b0;
      push(19, 0, 3'b000, 0, 0, 8'd0, "glitch_no_pllrst");
      push(20, 0, 3'b000, 0, 0, 8'd0, "glitch_no_early_rel");
      push(26, 0, 3'b000, 0, 0, 8'd0, "glitch_pre_d0");
      push(27, 0, 3'b001, 0, 0, 8'd0, "glitch_d0");
      push(31, 0, 3'b011, 0, 0, 8'd0, "glitch_d1");
      push(34, 0, 3'b011, 0, 0, 8'd0, "glitch_pre_d2");
      push(35, 0, 3'b111, 1, 0, 8'd0, "glitch_running");
      for (int t = 0; t <= 37; t++) begin
         @(posedge clk); #1;
         while (sb.size() > 0 && sb[0].cyc == t) begin
            e = sb.pop_front(); checks++;
            if ({pll_rst, domain_rst_n, running, fault, lock_loss_count} !== {e.pr, e.d, e.r, e.f, e.n}) begin
               errors++;
               $display("FAIL %s t=%0d: got rst=%b dom=%b run=%b flt=%b cnt=%0d, expected rst=%b dom=%b run=%b flt=%b cnt=%0d",
                        e.nm, t, pll_rst, domain_rst_n, running, fault, lock_loss_count, e.pr, e.d, e.r, e.f, e.n);
            end
         end
         if (t == 0)  rst_n = 1'b1;
         if (t == 10) pll_locked = 1'b1;
         if (t == 16) pll_locked = 1'b0;
         if (t == 17) pll_locked = 1'b1;
      end
      checks++;
      if (sb.size() != 0) begin errors++; $display("FAIL glitch_queue: %0d expectations left, expected 0", sb.size()); end
   endtask

   initial begin
      test_reset();
      test_normal();
      test_lock_loss_run();
      test_release_loss_saturate();
      test_restart_and_reset();
      test_never_lock();
      test_glitch();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
